ht_res_stats: RTL and testbench

//  Result-side stage directly downstream of hash_table_top: accepts ht_result_t on the

---
 rtl/ht_res_stats.sv | 175 +++++++++++++++++
 tb/tb_ht_res_stats.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ht_res_stats.sv
// Result-side statistics stage behind hash_table_top.
// Forwards results unchanged through a 2-entry skid buffer and keeps per-rescode event
// counters, an opcode/rescode consistency check, a sticky error flag and snapshot registers.

package hash_table;

    localparam int unsigned KEY_WIDTH   = 16;
    localparam int unsigned VALUE_WIDTH = 16;

    typedef enum logic [1:0] {
        OP_NOP    = 2'd0,
        OP_SEARCH = 2'd1,
        OP_INSERT = 2'd2,
        OP_DELETE = 2'd3
    } ht_opcode_t;

    // Encoding doubles as the counter index of each result code; 3'd7 is unused.
    typedef enum logic [2:0] {
        SEARCH_FOUND                     = 3'd0,
        SEARCH_NOT_SUCCESS_NO_ENTRY      = 3'd1,
        INSERT_SUCCESS                   = 3'd2,
        INSERT_SUCCESS_SAME_KEY          = 3'd3,
        INSERT_NOT_SUCCESS_TABLE_IS_FULL = 3'd4,
        DELETE_SUCCESS                   = 3'd5,
        DELETE_NOT_SUCCESS_NO_ENTRY      = 3'd6
    } ht_rescode_t;

    typedef struct packed {
        logic [KEY_WIDTH-1:0]   key;
        logic [VALUE_WIDTH-1:0] value;
        ht_opcode_t             opcode;
    } ht_command_t;

    typedef struct packed {
        ht_command_t            cmd;
        ht_rescode_t            rescode;
        logic [VALUE_WIDTH-1:0] found_value;
    } ht_result_t;

endpackage

module ht_res_stats
    import hash_table::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  ht_result_t                result_i,
    input  logic                      result_valid_i,
    output logic                      result_ready_o,
    output ht_result_t                result_o,
    output logic                      result_valid_o,
    input  logic                      result_ready_i,
    input  logic                      clear_i,
    input  logic                      snapshot_i,
    output logic [7:0][CNT_WIDTH-1:0] snap_cnt_o,
    output logic                      snap_valid_o,
    output logic                      err_o
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_t;

    state_t                    state_q;
    ht_result_t                head_q;
    ht_result_t                tail_q;
    logic                      ready_q;
    logic                      in_hs;
    logic                      out_hs;
    logic                      fam_ok;
    logic [2:0]                evt_idx;
    logic [7:0][CNT_WIDTH-1:0] cnt_q;
    logic [7:0][CNT_WIDTH-1:0] cnt_d;
    logic                      err_q;
    logic                      err_d;

    assign result_o       = head_q;
    assign result_valid_o = (state_q != StEmpty);
    assign result_ready_o = ready_q;
    assign in_hs          = result_valid_i && ready_q;
    assign out_hs         = result_valid_o && result_ready_i;
    assign err_o          = err_q;

    // Skid buffer: head_q is always the visible entry, tail_q holds the overflow entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StEmpty;
            head_q  <= '0;
            tail_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_hs) begin
                        head_q  <= result_i;
                        state_q <= StOne;
                    end
                end
                StOne: begin
                    if (in_hs && !out_hs) begin
                        tail_q  <= result_i;
                        state_q <= StTwo;
                        ready_q <= 1'b0;
                    end else if (in_hs && out_hs) begin
                        head_q <= result_i;
                    end else if (out_hs) begin
                        state_q <= StEmpty;
                    end
                end
                StTwo: begin
                    if (out_hs) begin
                        head_q  <= tail_q;
                        state_q <= StOne;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StEmpty;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Classify the incoming result: its own counter if the opcode family agrees, else slot 7.
    always_comb begin
        fam_ok = 1'b0;
        case (result_i.rescode)
            SEARCH_FOUND, SEARCH_NOT_SUCCESS_NO_ENTRY:
                fam_ok = (result_i.cmd.opcode == OP_SEARCH);
            INSERT_SUCCESS, INSERT_SUCCESS_SAME_KEY, INSERT_NOT_SUCCESS_TABLE_IS_FULL:
                fam_ok = (result_i.cmd.opcode == OP_INSERT);
            DELETE_SUCCESS, DELETE_NOT_SUCCESS_NO_ENTRY:
                fam_ok = (result_i.cmd.opcode == OP_DELETE);
            default:
                fam_ok = 1'b0;
        endcase
        evt_idx = fam_ok ? result_i.rescode : 3'd7;
    end

    // Next-state of live counters and error flag; clear wins but keeps a same-cycle event.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < 8; i++) begin
            if (clear_i) begin
                cnt_d[i] = (in_hs && evt_idx == 3'(i)) ? CNT_WIDTH'(1) : '0;
            end else if (in_hs && evt_idx == 3'(i) && cnt_q[i] != {CNT_WIDTH{1'b1}}) begin
                cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end
        end
        if (clear_i) begin
            err_d = in_hs && !fam_ok;
        end else begin
            err_d = err_q || (in_hs && !fam_ok);
        end
    end

    // Live counters, sticky error and snapshot copy of the pre-update counter values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            err_q        <= 1'b0;
            snap_cnt_o   <= '0;
            snap_valid_o <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            snap_valid_o <= snapshot_i;
            if (snapshot_i) begin
                snap_cnt_o <= cnt_q;
            end
        end
    end

endmodule

// File: tb/tb_ht_res_stats.sv
// Self-checking bench for ht_res_stats: a 32-bit and a 4-bit counter instance share stimulus
// and are compared against a queue/array reference model.

module tb_ht_res_stats;
    import hash_table::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    ht_result_t       result_i;
    logic             result_valid_i;
    logic             result_ready_i;
    logic             clear_i;
    logic             snapshot_i;

    logic             ready_o, valid_o, snap_valid_o, err_o;
    ht_result_t       result_o;
    logic [7:0][31:0] snap32;
    logic             ready4, valid4, snap_valid4, err4;
    ht_result_t       result4;
    logic [7:0][3:0]  snap4;

    ht_res_stats #(.CNT_WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .result_i(result_i), .result_valid_i(result_valid_i),
        .result_ready_o(ready_o), .result_o(result_o), .result_valid_o(valid_o),
        .result_ready_i(result_ready_i), .clear_i(clear_i), .snapshot_i(snapshot_i),
        .snap_cnt_o(snap32), .snap_valid_o(snap_valid_o), .err_o(err_o)
    );

    ht_res_stats #(.CNT_WIDTH(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .result_i(result_i), .result_valid_i(result_valid_i),
        .result_ready_o(ready4), .result_o(result4), .result_valid_o(valid4),
        .result_ready_i(result_ready_i), .clear_i(clear_i), .snapshot_i(snapshot_i),
        .snap_cnt_o(snap4), .snap_valid_o(snap_valid4), .err_o(err4)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: buffer contents, unbounded event counts, snapshot copies, error flag.
    ht_result_t q[$];
    longint     cnt_m[8];
    longint     snap_m[8];
    bit         err_m;
    bit         snapv_m;

    ht_opcode_t fam_tbl[7] = '{OP_SEARCH, OP_SEARCH, OP_INSERT, OP_INSERT, OP_INSERT,
                               OP_DELETE, OP_DELETE};

    function automatic int class_of(ht_result_t r);
        int rc = int'(r.rescode);
        if (rc < 7 && fam_tbl[rc] == r.cmd.opcode) return rc;
        return 7;
    endfunction

    function automatic longint sat(longint v, int w);
        longint mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic ht_result_t mk(ht_opcode_t op, ht_rescode_t rc);
        ht_result_t r;
        r.cmd.key     = 16'($urandom);
        r.cmd.value   = 16'($urandom);
        r.cmd.opcode  = op;
        r.rescode     = rc;
        r.found_value = 16'($urandom);
        return r;
    endfunction

    task automatic set_in(input bit v, input ht_result_t r, input bit rdy, input bit clr,
                          input bit snp);
        result_valid_i = v;
        result_i       = r;
        result_ready_i = rdy;
        clear_i        = clr;
        snapshot_i     = snp;
    endtask

    // One clock: advance the model with the inputs applied, return at the next negedge.
    task automatic tick();
        bit in_m, out_m;
        int k;
        in_m  = result_valid_i && (q.size() < 2);
        out_m = (q.size() > 0) && result_ready_i;
        @(posedge clk);
        if (rst) begin
            q.delete();
            foreach (cnt_m[i]) begin cnt_m[i] = 0; snap_m[i] = 0; end
            err_m   = 0;
            snapv_m = 0;
        end else begin
            if (snapshot_i) foreach (cnt_m[i]) snap_m[i] = cnt_m[i];
            snapv_m = snapshot_i;
            if (out_m) void'(q.pop_front());
            if (in_m) q.push_back(result_i);
            if (clear_i) begin
                foreach (cnt_m[i]) cnt_m[i] = 0;
                err_m = 0;
            end
            if (in_m) begin
                k = class_of(result_i);
                cnt_m[k]++;
                if (k == 7) err_m = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        total++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || result_o !== '0) begin
            bad++;
            $display("FAIL reset_port: valid=%b ready=%b result=%h, want 0 1 0",
                     valid_o, ready_o, result_o);
        end
        total++;
        if (err_o !== 1'b0 || snap_valid_o !== 1'b0 || snap32 !== '0 || snap4 !== '0) begin
            bad++;
            $display("FAIL reset_stats: err=%b snapv=%b snap32=%h snap4=%h, want all 0",
                     err_o, snap_valid_o, snap32, snap4);
        end
    endtask

    task automatic test_basic();
        ht_result_t r[4];
        longint     exp[8] = '{1, 0, 2, 0, 0, 1, 0, 0};
        r[0] = mk(OP_INSERT, INSERT_SUCCESS);
        r[1] = mk(OP_INSERT, INSERT_SUCCESS);
        r[2] = mk(OP_SEARCH, SEARCH_FOUND);
        r[3] = mk(OP_DELETE, DELETE_SUCCESS);
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, r[i], 1'b1, 1'b0, 1'b0);
            tick();
            total++;
            if (valid_o !== 1'b1 || result_o !== r[i]) begin
                bad++;
                $display("FAIL basic_out%0d: valid=%b result=%h, want 1 %h",
                         i, valid_o, result_o, r[i]);
            end
        end
        set_in(1'b0, '0, 1'b1, 1'b0, 1'b1);
        tick();
        total++;
        if (valid_o !== 1'b0) begin
            bad++;
            $display("FAIL basic_drain: valid=%b, want 0", valid_o);
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (snap_valid_o !== 1'b1 || snap32[i] !== 32'(exp[i])) begin
                bad++;
                $display("FAIL basic_snap%0d: snapv=%b snap=%0d, want 1 %0d",
                         i, snap_valid_o, snap32[i], exp[i]);
            end
        end
        total++;
        if (err_o !== 1'b0) begin
            bad++;
            $display("FAIL basic_err: err=%b, want 0", err_o);
        end
        set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick();
        total++;
        if (snap_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL basic_snapv_pulse: snapv=%b, want 0", snap_valid_o);
        end
    endtask

    task automatic test_backpressure();
        ht_result_t r[3];
        for (int i = 0; i < 3; i++) r[i] = mk(OP_SEARCH, SEARCH_NOT_SUCCESS_NO_ENTRY);
        set_in(1'b1, r[0], 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b1, r[1], 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b1, r[2], 1'b0, 1'b0, 1'b0);
        total++;
        if (ready_o !== 1'b0 || valid_o !== 1'b1 || result_o !== r[0]) begin
            bad++;
            $display("FAIL bp_full: ready=%b valid=%b result=%h, want 0 1 %h",
                     ready_o, valid_o, result_o, r[0]);
        end
        tick();
        total++;
        if (ready_o !== 1'b0 || result_o !== r[0]) begin
            bad++;
            $display("FAIL bp_hold: ready=%b result=%h, want 0 %h", ready_o, result_o, r[0]);
        end
        set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick();
        total++;
        if (valid_o !== 1'b1 || result_o !== r[1] || ready_o !== 1'b1) begin
            bad++;
            $display("FAIL bp_second: valid=%b ready=%b result=%h, want 1 1 %h",
                     valid_o, ready_o, result_o, r[1]);
        end
        tick();
        total++;
        if (valid_o !== 1'b0) begin
            bad++;
            $display("FAIL bp_nodup: valid=%b, want 0", valid_o);
        end
    endtask

    task automatic test_mismatch();
        set_in(1'b0, '0, 1'b1, 1'b1, 1'b0);
        tick();
        set_in(1'b1, mk(OP_SEARCH, DELETE_SUCCESS), 1'b1, 1'b0, 1'b0);
        tick();
        total++;
        if (err_o !== 1'b1) begin
            bad++;
            $display("FAIL mm_err: err=%b, want 1", err_o);
        end
        set_in(1'b0, '0, 1'b1, 1'b0, 1'b1);
        tick();
        total++;
        if (snap32[7] !== 32'd1 || snap32[5] !== 32'd0 || snap32[0] !== 32'd0) begin
            bad++;
            $display("FAIL mm_snap: [7]=%0d [5]=%0d [0]=%0d, want 1 0 0",
                     snap32[7], snap32[5], snap32[0]);
        end
        set_in(1'b0, '0, 1'b1, 1'b1, 1'b0);
        tick();
        total++;
        if (err_o !== 1'b0) begin
            bad++;
            $display("FAIL mm_clear_err: err=%b, want 0", err_o);
        end
        set_in(1'b0, '0, 1'b1, 1'b0, 1'b1);
        tick();
        total++;
        if (snap32 !== '0) begin
            bad++;
            $display("FAIL mm_clear_cnt: snap=%h, want 0", snap32);
        end
    endtask

    task automatic test_saturate();
        set_in(1'b0, '0, 1'b1, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, mk(OP_INSERT, INSERT_SUCCESS), 1'b1, 1'b0, 1'b0);
            tick();
        end
        set_in(1'b0, '0, 1'b1, 1'b0, 1'b1);
        tick();
        total++;
        if (snap4[2] !== 4'd15 || snap32[2] !== 32'd20) begin
            bad++;
            $display("FAIL sat: snap4[2]=%0d snap32[2]=%0d, want 15 20", snap4[2], snap32[2]);
        end
    endtask

    task automatic test_clear_snap();
        set_in(1'b0, '0, 1'b1, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, mk(OP_SEARCH, SEARCH_FOUND), 1'b1, 1'b0, 1'b0);
            tick();
        end
        set_in(1'b1, mk(OP_SEARCH, SEARCH_FOUND), 1'b1, 1'b1, 1'b1);
        tick();
        total++;
        if (snap_valid_o !== 1'b1 || snap32[0] !== 32'd3) begin
            bad++;
            $display("FAIL cs_pre: snapv=%b snap[0]=%0d, want 1 3", snap_valid_o, snap32[0]);
        end
        set_in(1'b0, '0, 1'b1, 1'b0, 1'b1);
        tick();
        total++;
        if (snap_valid_o !== 1'b1 || snap32[0] !== 32'd1) begin
            bad++;
            $display("FAIL cs_post: snapv=%b snap[0]=%0d, want 1 1", snap_valid_o, snap32[0]);
        end
    endtask

    task automatic test_reset_two();
        set_in(1'b1, mk(OP_INSERT, INSERT_SUCCESS_SAME_KEY), 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b1, mk(OP_DELETE, DELETE_NOT_SUCCESS_NO_ENTRY), 1'b0, 1'b0, 1'b0);
        tick();
        total++;
        if (ready_o !== 1'b0) begin
            bad++;
            $display("FAIL rt_full: ready=%b, want 0", ready_o);
        end
        rst = 1'b1;
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        total++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || result_o !== '0) begin
            bad++;
            $display("FAIL rt_port: valid=%b ready=%b result=%h, want 0 1 0",
                     valid_o, ready_o, result_o);
        end
        set_in(1'b0, '0, 1'b1, 1'b0, 1'b1);
        tick();
        total++;
        if (valid_o !== 1'b0 || snap32 !== '0 || snap4 !== '0) begin
            bad++;
            $display("FAIL rt_gone: valid=%b snap32=%h snap4=%h, want 0 0 0",
                     valid_o, snap32, snap4);
        end
    endtask

    task automatic test_random();
        ht_result_t r;
        int         errs = 0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 9) < 7) begin
                r = mk(OP_NOP, ht_rescode_t'(3'($urandom_range(0, 6))));
                r.cmd.opcode = fam_tbl[int'(r.rescode)];
            end else begin
                r = mk(ht_opcode_t'(2'($urandom)), ht_rescode_t'(3'($urandom)));
            end
            set_in(1'($urandom_range(0, 3) != 0), r, 1'($urandom_range(0, 2) != 0),
                   ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0));
            tick();
            total++;
            if (valid_o !== (q.size() > 0) || ready_o !== (q.size() < 2) ||
                (q.size() > 0 && result_o !== q[0])) begin
                bad++;
                errs++;
                if (errs < 10)
                    $display("FAIL rnd_stream@%0d: valid=%b ready=%b result=%h, want %b %b %h",
                             c, valid_o, ready_o, result_o, q.size() > 0, q.size() < 2,
                             (q.size() > 0) ? q[0] : '0);
            end
            total++;
            if (err_o !== err_m || err4 !== err_m || snap_valid_o !== snapv_m) begin
                bad++;
                errs++;
                if (errs < 10)
                    $display("FAIL rnd_flags@%0d: err=%b err4=%b snapv=%b, want %b %b %b",
                             c, err_o, err4, snap_valid_o, err_m, err_m, snapv_m);
            end
            if (snapv_m) begin
                for (int i = 0; i < 8; i++) begin
                    total++;
                    if (snap32[i] !== 32'(sat(snap_m[i], 32)) ||
                        snap4[i] !== 4'(sat(snap_m[i], 4))) begin
                        bad++;
                        errs++;
                        if (errs < 10)
                            $display("FAIL rnd_snap%0d@%0d: got %0d/%0d, want %0d/%0d",
                                     i, c, snap32[i], snap4[i],
                                     sat(snap_m[i], 32), sat(snap_m[i], 4));
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
        test_reset();
        test_basic();
        test_backpressure();
        test_mismatch();
        test_saturate();
        test_clear_snap();
        test_reset_two();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
